// File: rtl/rdata_checker.sv
// Read-return checker for the DDR3 Avalon traffic generator: tracks outstanding reads and checks each beat against the write pattern.
// Optional read-return timeout is built only when RDATA_CHECKER_TIMEOUT_EN is defined.
module rdata_checker #(
    parameter logic [24:0] NUM_BEATS       = 25'h1000001,
    parameter int          MAX_OUTSTANDING = 64,
    parameter int          TIMEOUT_CYCLES  = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        avl_ready,
    input  logic        avl_read_req,
    input  logic        avl_rdata_valid,
    input  logic [63:0] avl_rdata,
    output logic        is_finished,
    output logic        pass,
    output logic        fail,
    output logic [15:0] error_count,
    output logic [24:0] first_error_index,
    output logic [63:0] first_error_data,
    output logic [6:0]  outstanding
);

    localparam logic [63:0] PATTERN = 64'hdeadfadebabebeef;
    localparam logic [6:0]  MAX_OUT = 7'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        DONE_PASS = 2'd1,
        DONE_FAIL = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [24:0] beat_index_reg, beat_index_next;
    logic [6:0]  outstanding_reg, outstanding_next;
    logic [15:0] error_count_reg, error_count_next;
    logic [24:0] first_error_index_reg, first_error_index_next;
    logic [63:0] first_error_data_reg, first_error_data_next;

    logic [63:0] expected;
    logic        accept;
    logic        mismatch;
    logic        spurious;
    logic        overflow;
    logic        extra_beat;
    logic        timed_out;
    logic        fatal;

    // Expected beat is the write pattern with the low 25 bits folded with the beat index.
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi++) begin : g_expected
            if (gi < 25) begin : g_idx
                assign expected[gi] = PATTERN[gi] ^ beat_index_reg[gi];
            end else begin : g_const
                assign expected[gi] = PATTERN[gi];
            end
        end
    endgenerate

    assign accept     = avl_read_req && avl_ready;
    assign mismatch   = (avl_rdata != expected);
    assign spurious   = avl_rdata_valid && (outstanding_reg == 7'd0);
    assign overflow   = accept && (outstanding_reg == MAX_OUT);
    assign extra_beat = avl_rdata_valid && (beat_index_reg == NUM_BEATS);
    assign fatal      = spurious || overflow || extra_beat || timed_out;

`ifdef RDATA_CHECKER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] timeout_count_reg;

    // Counts idle cycles while reads are pending; any return or an empty pipe restarts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_count_reg <= '0;
        end else if (state_reg == CHECK) begin
            if (avl_rdata_valid || (outstanding_reg == 7'd0)) begin
                timeout_count_reg <= '0;
            end else if (timeout_count_reg != TIMEOUT_LIMIT) begin
                timeout_count_reg <= timeout_count_reg + 1'b1;
            end
        end
    end

    assign timed_out = (timeout_count_reg == TIMEOUT_LIMIT);
`else
    // No timeout in this build; the compare only keeps the parameter referenced.
    assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_next             = state_reg;
        beat_index_next        = beat_index_reg;
        outstanding_next       = outstanding_reg;
        error_count_next       = error_count_reg;
        first_error_index_next = first_error_index_reg;
        first_error_data_next  = first_error_data_reg;
        is_finished            = 1'b0;
        pass                   = 1'b0;
        fail                   = 1'b0;

        case (state_reg)
            CHECK: begin
                if (fatal) begin
                    // Offending cycle freezes the counters so diagnostics show the pre-fault picture.
                    state_next = DONE_FAIL;
                end else begin
                    case ({accept, avl_rdata_valid})
                        2'b10:   outstanding_next = outstanding_reg + 7'd1;
                        2'b01:   outstanding_next = outstanding_reg - 7'd1;
                        default: outstanding_next = outstanding_reg;
                    endcase
                    if (avl_rdata_valid) begin
                        beat_index_next = beat_index_reg + 25'd1;
                        if (mismatch) begin
                            if (error_count_reg != 16'hffff) begin
                                error_count_next = error_count_reg + 16'd1;
                            end
                            if (error_count_reg == 16'd0) begin
                                first_error_index_next = beat_index_reg;
                                first_error_data_next  = avl_rdata;
                            end
                        end
                    end
                    // Decide on next-cycle values so the verdict lands one cycle after the last beat.
                    if ((beat_index_next == NUM_BEATS) && (outstanding_next == 7'd0)) begin
                        state_next = (error_count_next == 16'd0) ? DONE_PASS : DONE_FAIL;
                    end
                end
            end
            DONE_PASS: begin
                is_finished = 1'b1;
                pass        = 1'b1;
            end
            DONE_FAIL: begin
                is_finished = 1'b1;
                fail        = 1'b1;
            end
            default: begin
                state_next = DONE_FAIL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg             <= CHECK;
            beat_index_reg        <= '0;
            outstanding_reg       <= '0;
            error_count_reg       <= '0;
            first_error_index_reg <= '0;
            first_error_data_reg  <= '0;
        end else begin
            state_reg             <= state_next;
            beat_index_reg        <= beat_index_next;
            outstanding_reg       <= outstanding_next;
            error_count_reg       <= error_count_next;
            first_error_index_reg <= first_error_index_next;
            first_error_data_reg  <= first_error_data_next;
        end
    end

    assign error_count       = error_count_reg;
    assign first_error_index = first_error_index_reg;
    assign first_error_data  = first_error_data_reg;
    assign outstanding       = outstanding_reg;

endmodule
